// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, PC-select encodings and the fetch FSM state type.
package cpu_pkg;

  localparam int unsigned AW     = 64;
  localparam int unsigned IW     = 32;
  localparam int unsigned QDEPTH = 2;

  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_LOAD = 2'b10;
  localparam logic [1:0] PS_REL  = 2'b11;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'b00,
    FETCH_REQ  = 2'b01,
    FETCH_WAIT = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: PC sampling, instruction-memory handshake and decode-side queue head.
interface instr_fetch_if;
  import cpu_pkg::*;

  logic          pc_advance;
  logic [AW-1:0] pc;
  logic          flush;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [IW-1:0] mem_rdata;
  logic          ir_valid;
  logic [IW-1:0] ir;
  logic [AW-1:0] ir_pc;
  logic          ir_ready;

  modport master (
    input  pc, flush, mem_gnt, mem_rvalid, mem_rdata, ir_ready,
    output pc_advance, mem_req, mem_addr, ir_valid, ir, ir_pc
  );

  modport slave (
    output pc, flush, mem_gnt, mem_rvalid, mem_rdata, ir_ready,
    input  pc_advance, mem_req, mem_addr, ir_valid, ir, ir_pc
  );

endinterface

// File: rtl/fetch_queue.sv
// Two-entry instruction FIFO between fetch and decode; entries carry their fetch address.
module fetch_queue
  import cpu_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          clear_i,
  input  logic [IW-1:0] push_instr_i,
  input  logic [AW-1:0] push_pc_i,
  output logic          valid_o,
  output logic [IW-1:0] instr_o,
  output logic [AW-1:0] pc_o,
  output logic [1:0]    count_o
);

  logic [IW-1:0] instr_q [QDEPTH];
  logic [AW-1:0] pc_q    [QDEPTH];
  logic          head_q, head_d;
  logic [1:0]    count_q, count_d;
  logic          tail;
  logic          do_pop;

  assign do_pop = pop_i && (count_q != 2'd0);
  assign tail   = head_q ^ count_q[0];

  always_comb begin
    head_d  = head_q;
    count_d = count_q;
    if (clear_i) begin
      count_d = 2'd0;
    end else begin
      case ({push_i, do_pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
      if (do_pop) head_d = ~head_q;
    end
  end

  // A flush drops queued entries but leaves storage alone so the head simply holds its last value.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= 1'b0;
      count_q <= 2'd0;
      for (int i = 0; i < QDEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else begin
      head_q  <= head_d;
      count_q <= count_d;
      if (push_i && !clear_i) begin
        instr_q[tail] <= push_instr_i;
        pc_q[tail]    <= push_pc_i;
      end
    end
  end

  assign valid_o = (count_q != 2'd0);
  assign instr_o = instr_q[head_q];
  assign pc_o    = pc_q[head_q];
  assign count_o = count_q;

  a_no_push_when_full : assert property (@(posedge clock) disable iff (reset)
    !(push_i && !clear_i && count_q == 2'd2));

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: one outstanding memory read at a time, feeding a 2-entry decode queue.
module instr_fetch
  import cpu_pkg::*;
(
  input logic            clock,
  input logic            reset,
  instr_fetch_if.master  bus
);

  fetch_state_e  state_q, state_d;
  logic [AW-1:0] req_addr_q, req_addr_d;
  logic          kill_q, kill_d;
  logic          push;
  logic          pop;
  logic [1:0]    count;

  // A response is kept only if no flush was seen between its grant and its arrival.
  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    kill_d     = kill_q;
    push       = 1'b0;
    case (state_q)
      FETCH_IDLE: begin
        if (!bus.flush && (count < 2'd2)) begin
          state_d    = FETCH_REQ;
          req_addr_d = bus.pc;
        end
      end
      FETCH_REQ: begin
        if (bus.mem_gnt) begin
          state_d = FETCH_WAIT;
          kill_d  = bus.flush;
        end else if (bus.flush) begin
          state_d = FETCH_IDLE;
        end
      end
      FETCH_WAIT: begin
        if (bus.mem_rvalid) begin
          push    = !(kill_q || bus.flush);
          kill_d  = 1'b0;
          state_d = FETCH_IDLE;
        end else if (bus.flush) begin
          kill_d = 1'b1;
        end
      end
      default: state_d = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= FETCH_IDLE;
      req_addr_q <= '0;
      kill_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      kill_q     <= kill_d;
    end
  end

  assign bus.mem_req    = (state_q == FETCH_REQ);
  assign bus.mem_addr   = req_addr_q;
  assign bus.pc_advance = (state_q == FETCH_REQ) && bus.mem_gnt && !bus.flush;
  assign pop            = bus.ir_valid && bus.ir_ready;

  fetch_queue u_queue (
    .clock        (clock),
    .reset        (reset),
    .push_i       (push),
    .pop_i        (pop),
    .clear_i      (bus.flush),
    .push_instr_i (bus.mem_rdata),
    .push_pc_i    (req_addr_q),
    .valid_o      (bus.ir_valid),
    .instr_o      (bus.ir),
    .pc_o         (bus.ir_pc),
    .count_o      (count)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: vector table, multi-cycle handshake sequences and a randomized run
// against a transaction-level model of the fetch queue and PC.
module tb_instr_fetch;
  import cpu_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  instr_fetch_if bus();

  instr_fetch dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst, flush, gnt, rvalid, ready;
    logic [31:0] rdata;
    logic [63:0] pc;
    logic        eReq, eAdv, eIrv;
    logic [31:0] eIr;
    logic [63:0] eIrPc, eAddr;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
  } entry_t;

  vec_t vecs[$];

  function automatic logic [31:0] memData(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    bus.flush      = 1'b0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
  endtask

  task automatic addVec(input logic rst, f, g, v, input logic [31:0] d, input logic rdy,
                        input logic [63:0] pc, input logic eReq, eAdv, eIrv,
                        input logic [31:0] eIr, input logic [63:0] eIrPc, eAddr);
    vec_t t;
    t.rst = rst; t.flush = f; t.gnt = g; t.rvalid = v; t.rdata = d; t.ready = rdy; t.pc = pc;
    t.eReq = eReq; t.eAdv = eAdv; t.eIrv = eIrv; t.eIr = eIr; t.eIrPc = eIrPc; t.eAddr = eAddr;
    vecs.push_back(t);
  endtask

  task automatic applyStimulus(input vec_t t);
    reset          = t.rst;
    bus.flush      = t.flush;
    bus.mem_gnt    = t.gnt;
    bus.mem_rvalid = t.rvalid;
    bus.mem_rdata  = t.rdata;
    bus.ir_ready   = t.ready;
    bus.pc         = t.pc;
  endtask

  task automatic checkOutput(input vec_t t, input int idx);
    check($sformatf("vec%0d_mem_req", idx), bus.mem_req, t.eReq);
    check($sformatf("vec%0d_pc_advance", idx), bus.pc_advance, t.eAdv);
    check($sformatf("vec%0d_ir_valid", idx), bus.ir_valid, t.eIrv);
    check($sformatf("vec%0d_mem_addr", idx), bus.mem_addr, t.eAddr);
    if (t.eIrv) begin
      check($sformatf("vec%0d_ir", idx), bus.ir, t.eIr);
      check($sformatf("vec%0d_ir_pc", idx), bus.ir_pc, t.eIrPc);
    end
  endtask

  // Two reset cycles with a stray response toggling underneath; everything must read as zero.
  task automatic applyReset();
    reset          = 1'b1;
    bus.flush      = 1'b0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.ir_ready   = 1'b0;
    tick();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hF00D_F00D;
    @(negedge clock);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_pc_advance", bus.pc_advance, 0);
    check("rst_ir_valid", bus.ir_valid, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_ir", bus.ir, 0);
    check("rst_ir_pc", bus.ir_pc, 0);
    tick();
    reset = 1'b0;
  endtask

  task automatic idleCheck(input string tag, input logic hv, input logic [31:0] hd,
                           input logic [63:0] hp, input logic eReq);
    @(negedge clock);
    check({tag, "_ir_valid"}, bus.ir_valid, hv);
    if (hv) begin
      check({tag, "_ir"}, bus.ir, hd);
      check({tag, "_ir_pc"}, bus.ir_pc, hp);
    end
    check({tag, "_mem_req"}, bus.mem_req, eReq);
    check({tag, "_pc_advance"}, bus.pc_advance, 0);
    tick();
  endtask

  // One full fetch starting from an idle cycle. flushMode: 0 none, 1 at grant,
  // 2 one cycle after grant, 3 together with the response.
  task automatic fetchOne(input string tag, input logic [63:0] addr, input logic [31:0] data,
                          input int gntDly, input int rvDly, input int flushMode,
                          input logic hv, input logic [31:0] hd, input logic [63:0] hp,
                          input logic popAtRv);
    bus.pc = addr;
    idleCheck({tag, "_idle"}, hv, hd, hp, 1'b0);
    for (int i = 0; i < gntDly; i++) begin
      @(negedge clock);
      check({tag, "_req_hold"}, bus.mem_req, 1);
      check({tag, "_addr_hold"}, bus.mem_addr, addr);
      check({tag, "_adv_early"}, bus.pc_advance, 0);
      tick();
    end
    bus.mem_gnt = 1'b1;
    bus.flush   = (flushMode == 1);
    @(negedge clock);
    check({tag, "_req_gnt"}, bus.mem_req, 1);
    check({tag, "_addr_gnt"}, bus.mem_addr, addr);
    check({tag, "_adv_gnt"}, bus.pc_advance, flushMode != 1);
    tick();
    for (int i = 1; i < rvDly; i++) begin
      bus.flush = (flushMode == 2) && (i == 1);
      @(negedge clock);
      check({tag, "_req_wait"}, bus.mem_req, 0);
      check({tag, "_adv_wait"}, bus.pc_advance, 0);
      tick();
    end
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = data;
    bus.flush      = (flushMode == 3);
    if (popAtRv) bus.ir_ready = 1'b1;
    @(negedge clock);
    check({tag, "_req_rv"}, bus.mem_req, 0);
    check({tag, "_adv_rv"}, bus.pc_advance, 0);
    if (popAtRv) check({tag, "_head_at_rv"}, bus.ir_valid, 1);
    tick();
  endtask

  task automatic runRandom(input int cycles);
    logic [63:0] pcReg, outAddr, target;
    logic        outstanding, outKill, reqSeen;
    logic        flushNow, gntNow, rvNow, rdyNow, popNow, pushNow;
    int          gntWait, rvWait, delivered;
    entry_t      sbq[$];
    entry_t      e;
    pcReg = {$urandom, $urandom};
    outAddr = '0; outstanding = 0; outKill = 0; reqSeen = 0;
    gntWait = 0; rvWait = 0; delivered = 0;
    for (int c = 0; c < cycles; c++) begin
      flushNow = ($urandom_range(0, 11) == 0);
      target   = {$urandom, $urandom};
      rdyNow   = ($urandom_range(0, 9) < 7);
      gntNow   = 1'b0;
      if (bus.mem_req) begin
        if (!reqSeen) begin
          reqSeen = 1'b1;
          gntWait = $urandom_range(0, 3);
        end
        if (gntWait == 0) gntNow = 1'b1;
        else gntWait--;
      end
      rvNow = 1'b0;
      if (outstanding) begin
        if (rvWait == 0) rvNow = 1'b1;
        else rvWait--;
      end
      bus.pc         = pcReg;
      bus.flush      = flushNow;
      bus.mem_gnt    = gntNow;
      bus.mem_rvalid = rvNow;
      bus.mem_rdata  = rvNow ? memData(outAddr) : $urandom;
      bus.ir_ready   = rdyNow;
      @(negedge clock);
      check("rnd_pc_advance", bus.pc_advance, bus.mem_req && gntNow && !flushNow);
      if (bus.mem_req && gntNow) check("rnd_grant_addr", bus.mem_addr, pcReg);
      if (outstanding) check("rnd_single_outstanding", bus.mem_req, 0);
      check("rnd_ir_valid", bus.ir_valid, sbq.size() != 0);
      if (sbq.size() != 0) begin
        check("rnd_ir", bus.ir, sbq[0].instr);
        check("rnd_ir_pc", bus.ir_pc, sbq[0].pc);
      end
      popNow   = (sbq.size() != 0) && rdyNow;
      pushNow  = rvNow && !outKill && !flushNow;
      e.instr  = memData(outAddr);
      e.pc     = outAddr;
      if (rvNow) outstanding = 1'b0;
      else if (outstanding && flushNow) outKill = 1'b1;
      if (bus.mem_req && gntNow) begin
        outstanding = 1'b1;
        outAddr     = pcReg;
        outKill     = flushNow;
        rvWait      = $urandom_range(0, 3);
      end
      if (bus.mem_req && (gntNow || flushNow)) reqSeen = 1'b0;
      if (flushNow) begin
        sbq.delete();
      end else begin
        if (popNow) void'(sbq.pop_front());
        if (pushNow) begin
          check("rnd_no_overflow", sbq.size() < 2, 1);
          sbq.push_back(e);
          delivered++;
        end
      end
      if (flushNow) pcReg = target;
      else if (bus.mem_req && gntNow) pcReg = pcReg + 64'd4;
      tick();
    end
    check("rnd_progress", delivered > 100, 1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.pc = '0; bus.flush = 0; bus.mem_gnt = 0; bus.mem_rvalid = 0;
    bus.mem_rdata = '0; bus.ir_ready = 0;

    //     rst f g v rdata         rdy pc          req adv irv ir            ir_pc      mem_addr
    addVec(1, 0, 0, 1, 32'hBAD00001, 0, 64'h0,     0, 0, 0, 32'h0,        64'h0,     64'h0);
    addVec(1, 0, 0, 0, 32'h0,        0, 64'h0,     0, 0, 0, 32'h0,        64'h0,     64'h0);
    addVec(1, 0, 0, 1, 32'hBAD00002, 0, 64'h0,     0, 0, 0, 32'h0,        64'h0,     64'h0);
    addVec(0, 0, 0, 0, 32'h0,        1, 64'hFFF,   0, 0, 0, 32'h0,        64'h0,     64'h0);
    addVec(0, 0, 1, 0, 32'h0,        1, 64'hFFF,   1, 1, 0, 32'h0,        64'h0,     64'hFFF);
    addVec(0, 0, 0, 1, 32'h11111111, 1, 64'h1FFF,  0, 0, 0, 32'h0,        64'h0,     64'hFFF);
    addVec(0, 0, 0, 0, 32'h0,        1, 64'h1FFF,  0, 0, 1, 32'h11111111, 64'hFFF,   64'hFFF);
    addVec(0, 0, 1, 0, 32'h0,        1, 64'h1FFF,  1, 1, 0, 32'h0,        64'h0,     64'h1FFF);
    addVec(0, 0, 0, 1, 32'h22222222, 1, 64'h2003,  0, 0, 0, 32'h0,        64'h0,     64'h1FFF);
    addVec(0, 0, 0, 0, 32'h0,        0, 64'h2003,  0, 0, 1, 32'h22222222, 64'h1FFF,  64'h1FFF);
    addVec(0, 1, 1, 0, 32'h0,        0, 64'h2003,  1, 0, 1, 32'h22222222, 64'h1FFF,  64'h2003);
    addVec(0, 0, 0, 1, 32'hDEADBEEF, 1, 64'h8FFF,  0, 0, 0, 32'h0,        64'h0,     64'h2003);
    addVec(0, 0, 0, 0, 32'h0,        1, 64'h8FFF,  0, 0, 0, 32'h0,        64'h0,     64'h2003);
    addVec(0, 0, 1, 0, 32'h0,        1, 64'h8FFF,  1, 1, 0, 32'h0,        64'h0,     64'h8FFF);
    addVec(0, 1, 0, 1, 32'h33333333, 1, 64'h9003,  0, 0, 0, 32'h0,        64'h0,     64'h8FFF);
    addVec(0, 0, 0, 0, 32'h0,        1, 64'hA000,  0, 0, 0, 32'h0,        64'h0,     64'h8FFF);
    addVec(0, 1, 0, 0, 32'h0,        1, 64'hA000,  1, 0, 0, 32'h0,        64'h0,     64'hA000);
    addVec(0, 0, 0, 0, 32'h0,        1, 64'hB000,  0, 0, 0, 32'h0,        64'h0,     64'hA000);
    addVec(0, 0, 1, 0, 32'h0,        1, 64'hB000,  1, 1, 0, 32'h0,        64'h0,     64'hB000);
    addVec(0, 0, 0, 1, 32'h44444444, 1, 64'hB004,  0, 0, 0, 32'h0,        64'h0,     64'hB000);
    addVec(0, 0, 0, 0, 32'h0,        1, 64'hB004,  0, 0, 1, 32'h44444444, 64'hB000,  64'hB000);
    addVec(1, 0, 0, 0, 32'h0,        1, 64'hB004,  1, 0, 0, 32'h0,        64'h0,     64'hB004);
    addVec(1, 0, 0, 1, 32'h55555555, 1, 64'hC000,  0, 0, 0, 32'h0,        64'h0,     64'h0);
    addVec(0, 0, 0, 1, 32'h66666666, 1, 64'hC000,  0, 0, 0, 32'h0,        64'h0,     64'h0);
    addVec(0, 0, 0, 0, 32'h0,        1, 64'hC000,  1, 0, 0, 32'h0,        64'h0,     64'hC000);

    applyReset();
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      @(negedge clock);
      checkOutput(vecs[i], i);
      tick();
    end

    // Decode stalled: two fetches fill the queue, issue stops, then resumes in order.
    applyReset();
    fetchOne("bp1", 64'h100, 32'hA0A0A0A0, 0, 1, 0, 0, 32'h0, 64'h0, 0);
    fetchOne("bp2", 64'h104, 32'hB0B0B0B0, 0, 1, 0, 1, 32'hA0A0A0A0, 64'h100, 0);
    for (int i = 0; i < 3; i++) idleCheck("bp_full", 1, 32'hA0A0A0A0, 64'h100, 0);
    bus.ir_ready = 1'b1;
    idleCheck("bp_pop1", 1, 32'hA0A0A0A0, 64'h100, 0);
    bus.ir_ready = 1'b0;
    fetchOne("bp3", 64'h108, 32'hC0C0C0C0, 0, 1, 0, 1, 32'hB0B0B0B0, 64'h104, 0);
    idleCheck("bp_full2", 1, 32'hB0B0B0B0, 64'h104, 0);
    bus.ir_ready = 1'b1;
    idleCheck("bp_pop2", 1, 32'hB0B0B0B0, 64'h104, 0);
    idleCheck("bp_pop3", 1, 32'hC0C0C0C0, 64'h108, 0);

    // Slow memory: grant after 3 cycles, response 5 cycles after grant.
    applyReset();
    fetchOne("lat", 64'h3000, 32'h13572468, 3, 5, 0, 0, 32'h0, 64'h0, 0);
    idleCheck("lat_out", 1, 32'h13572468, 64'h3000, 0);

    // Flush while waiting: response dropped, next fetch from the redirect target.
    applyReset();
    fetchOne("fw", 64'h2FFF, 32'hDEADBEEF, 0, 3, 2, 0, 32'h0, 64'h0, 0);
    fetchOne("fw_next", 64'h8FFF, 32'h600D600D, 0, 1, 0, 0, 32'h0, 64'h0, 0);
    idleCheck("fw_out", 1, 32'h600D600D, 64'h8FFF, 0);

    // Flush together with a pop and an arriving response: queue ends empty.
    applyReset();
    fetchOne("fpp1", 64'h400, 32'hE0E0E0E0, 0, 1, 0, 0, 32'h0, 64'h0, 0);
    fetchOne("fpp2", 64'h404, 32'hF0F0F0F0, 0, 2, 3, 1, 32'hE0E0E0E0, 64'h400, 1);
    bus.ir_ready = 1'b0;
    idleCheck("fpp_after", 0, 32'h0, 64'h0, 0);
    idleCheck("fpp_after2", 0, 32'h0, 64'h0, 1);

    applyReset();
    runRandom(3000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
